sevenseg_port: RTL and testbench

- Memory-mapped N-digit seven-segment output peripheral for the basic processor.
- A CPU write to the port address latches a word and shows it on NDIG active-low digits, in hex or decimal.
- Decimal mode uses an iterative double-dabble converter, so the display updates without glitching.
- One-deep pending buffer accepts a write while a conversion is in flight; it replaces the fixed two-digit display decoder at the CPU top level.

---
 rtl/sevenseg_pkg.sv | 26 ++
 rtl/sevenseg_port_if.sv | 14 +
 rtl/sevenseg_port_seg_decode.sv | 9 +
 rtl/sevenseg_port.sv | 166 ++++++++++++++++
 tb/tb_sevenseg_port.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display port: FSM states,
// active-low segment codes and the decimal digit-count helper.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // gfedcba, active-low, index = nibble value
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Decimal digits in 2**width-1, i.e. floor(width*log10(2))+1.
  function automatic int dec_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/sevenseg_port_if.sv
// CPU write path into the display port, plus the busy indication back to the CPU.
interface sevenseg_port_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              dec_mode;
  logic              busy;

  modport master (output wr_en, wr_addr, wr_data, dec_mode, input busy);
  modport slave  (input wr_en, wr_addr, wr_data, dec_mode, output busy);
endinterface

// File: rtl/sevenseg_port_seg_decode.sv
// Nibble to active-low gfedcba segment pattern, purely combinational.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_CODE[nib];
endmodule

// File: rtl/sevenseg_port.sv
// Memory-mapped N-digit seven-segment port with hex or double-dabble decimal display.
// Build option SEVENSEG_BLANK_EN blanks leading-zero digits (digit 0 always shown).
//
// state | meaning
// IDLE  | no conversion; a hit (or held pending entry) starts here
// SHIFT | double-dabble: adjust BCD nibbles then shift, WORD_W times
// DONE  | commit BCD result to display, then start pending entry or idle
module sevenseg_port
  import sevenseg_pkg::*;
#(
  parameter int              WORD_W    = 8,
  parameter int              ADDR_W    = 5,
  parameter int              NDIG      = 3,
  parameter logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(31)
) (
  input  logic                 clock,
  input  logic                 reset,
  sevenseg_port_if.slave       bus,
  output logic [WORD_W-1:0]    value,
  output logic [NDIG*7-1:0]    HEX
);

  localparam int BCD_W = NDIG * 4;
  localparam int CNT_W = $clog2(WORD_W + 1);

  if (NDIG < (WORD_W + 3) / 4 || NDIG < dec_digits(WORD_W)) begin : g_bad_ndig
    $error("sevenseg_port: NDIG too small to show a WORD_W-bit word");
  end

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shift_reg, word_reg, pend_data, start_data;
  logic [BCD_W-1:0]   bcd, bcd_adj, disp;
  logic [CNT_W-1:0]   cnt;
  logic               pend_valid, pend_mode, start_mode;
  logic               hit, load_dec, commit_hex, commit_bcd, shift_en, pend_load, pend_clr;

  assign hit      = bus.wr_en && (bus.wr_addr == PORT_ADDR);
  assign bus.busy = (state != IDLE) || pend_valid;

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_data = bus.wr_data;
    start_mode = bus.dec_mode;
    load_dec   = 1'b0;
    commit_hex = 1'b0;
    commit_bcd = 1'b0;
    shift_en   = 1'b0;
    pend_load  = 1'b0;
    pend_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        // a fresh hit supersedes a held pending entry (last write wins)
        if (!hit && pend_valid) begin
          start_data = pend_data;
          start_mode = pend_mode;
        end
        if (hit || pend_valid) begin
          pend_clr = 1'b1;
          if (start_mode) begin
            load_dec  = 1'b1;
            state_nxt = SHIFT;
          end else begin
            commit_hex = 1'b1;
          end
        end
      end
      SHIFT: begin
        shift_en  = 1'b1;
        pend_load = hit;
        if (cnt == CNT_W'(WORD_W - 1)) state_nxt = DONE;
      end
      DONE: begin
        commit_bcd = 1'b1;
        pend_load  = hit;
        state_nxt  = IDLE;
        // pending hex entries are left held and committed from IDLE next edge
        if (pend_valid && pend_mode) begin
          start_data = pend_data;
          load_dec   = 1'b1;
          pend_clr   = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      word_reg   <= '0;
      bcd        <= '0;
      cnt        <= '0;
      value      <= '0;
      disp       <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_mode  <= 1'b0;
    end else begin
      if (load_dec) begin
        shift_reg <= start_data;
        word_reg  <= start_data;
        bcd       <= '0;
        cnt       <= '0;
      end else if (shift_en) begin
        {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
        cnt              <= cnt + 1'b1;
      end
      if (commit_hex) begin
        value <= start_data;
        disp  <= BCD_W'(start_data);
      end
      if (commit_bcd) begin
        value <= word_reg;
        disp  <= bcd;
      end
      if (pend_clr) pend_valid <= 1'b0;
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_data  <= bus.wr_data;
        pend_mode  <= bus.dec_mode;
      end
    end
  end

  logic [6:0] seg_raw [NDIG];

`ifdef SEVENSEG_BLANK_EN
  logic [NDIG-1:0] blank;
  logic            zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp[4*k +: 4] == 4'd0);
      blank[k] = zero_run;
    end
  end
`endif

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    seg_decode u_dec (
      .nib (disp[4*k +: 4]),
      .seg (seg_raw[k])
    );
`ifdef SEVENSEG_BLANK_EN
    assign HEX[7*k +: 7] = blank[k] ? SEG_BLANK : seg_raw[k];
`else
    assign HEX[7*k +: 7] = seg_raw[k];
`endif
  end

endmodule

// File: tb/tb_sevenseg_port.sv
// Self-checking bench for sevenseg_port: directed scenarios plus random writes
// compared cycle by cycle against a latency-level reference model.
module tb_sevenseg_port;

  localparam int WORD_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int NDIG      = 3;
  localparam int PORT_ADDR = 31;

`ifdef SEVENSEG_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic                 clock;
  logic                 reset;
  logic [WORD_W-1:0]    value;
  logic [NDIG*7-1:0]    HEX;

  sevenseg_port_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  sevenseg_port #(
    .WORD_W    (WORD_W),
    .ADDR_W    (ADDR_W),
    .NDIG      (NDIG),
    .PORT_ADDR (5'd31)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .value (value),
    .HEX   (HEX)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks what is shown and when, in terms of write latencies.
  int m_val;
  bit m_dec;
  bit job_v;
  int job_d;
  int job_left;
  bit pend_v;
  int pend_d;
  bit pend_dec;

  function automatic logic [NDIG*7-1:0] exp_hex(input int v, input bit dec);
    logic [NDIG*7-1:0] r;
    int base;
    int rem;
    r    = '0;
    base = dec ? 10 : 16;
    rem  = v;
    for (int k = 0; k < NDIG; k++) begin
      if (BLANK_EN && k > 0 && rem == 0) r[7*k +: 7] = 7'b1111111;
      else                               r[7*k +: 7] = SEG_TBL[rem % base];
      rem = rem / base;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_dec  = 1'b0;
    job_v  = 1'b0;
    job_d  = 0;
    job_left = 0;
    pend_v = 1'b0;
    pend_d = 0;
    pend_dec = 1'b0;
  endtask

  task automatic model_edge(input bit h, input int d, input bit m);
    bit sv;
    int sd;
    bit sm;
    if (job_v) begin
      job_left--;
      if (job_left == 0) begin
        m_val = job_d;
        m_dec = 1'b1;
        job_v = 1'b0;
        if (pend_v && pend_dec) begin
          job_v    = 1'b1;
          job_d    = pend_d;
          job_left = WORD_W + 1;
          pend_v   = 1'b0;
        end
      end
      if (h) begin
        pend_v   = 1'b1;
        pend_d   = d;
        pend_dec = m;
      end
    end else begin
      sv = 1'b0; sd = 0; sm = 1'b0;
      if (h) begin
        sv = 1'b1; sd = d; sm = m;
      end else if (pend_v) begin
        sv = 1'b1; sd = pend_d; sm = pend_dec;
      end
      pend_v = 1'b0;
      if (sv) begin
        if (sm) begin
          job_v    = 1'b1;
          job_d    = sd;
          job_left = WORD_W + 1;
        end else begin
          m_val = sd;
          m_dec = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy",  {31'd0, bus.busy}, {31'd0, (job_v || pend_v)});
    check("value", {24'd0, value}, m_val);
    check("hex",   {11'd0, HEX}, {11'd0, exp_hex(m_val, m_dec)});
  endtask

  task automatic step(input bit en, input int addr, input int data, input bit mode);
    logic [31:0] a;
    logic [31:0] d;
    a = addr;
    d = data;
    bus.wr_en    = en;
    bus.wr_addr  = a[ADDR_W-1:0];
    bus.wr_data  = d[WORD_W-1:0];
    bus.dec_mode = mode;
    @(posedge clock);
    model_edge(en && (addr == PORT_ADDR), data & 255, mode);
    #1;
    bus.wr_en = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    int bcnt;
    int gap;
    bit seen7;
    bit seen100;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.dec_mode = 1'b0;
    reset        = 1'b1;
    model_reset();
    #2;
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // hex write: immediate update, busy never raised
    step(1'b1, 31, 8'hA5, 1'b0);
    check("hex_a5_value", {24'd0, value}, 32'hA5);
    idle(2);

    // decimal 255: busy for exactly WORD_W+1 cycles
    step(1'b1, 31, 255, 1'b1);
    bcnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 30 && bus.busy; i++) begin
      step(1'b0, 0, 0, 1'b0);
      if (bus.busy) bcnt++;
    end
    check("dec255_busy_cycles", bcnt, WORD_W + 1);
    check("dec255_value", {24'd0, value}, 32'd255);

    // write to another address is ignored
    step(1'b1, 30, 8'h3C, 1'b1);
    idle(3);

    // pending overwrite: 100, then 7 and 42 during conversion
    seen7 = 1'b0; seen100 = 1'b0; gap = 0;
    step(1'b1, 31, 100, 1'b1);
    idle(2);
    step(1'b1, 31, 7, 1'b1);
    idle(1);
    step(1'b1, 31, 42, 1'b1);
    for (int i = 0; i < 60 && value != 8'd42; i++) begin
      if (!bus.busy) gap++;
      step(1'b0, 0, 0, 1'b0);
      if (value == 8'd7)   seen7 = 1'b1;
      if (value == 8'd100) seen100 = 1'b1;
    end
    check("pend_seen100", {31'd0, seen100}, 32'd1);
    check("pend_seen7",   {31'd0, seen7}, 32'd0);
    check("pend_busy_gap", gap, 0);
    check("pend_final", {24'd0, value}, 32'd42);
    idle(2);

    // hex hit landing on the DONE cycle of decimal 9
    step(1'b1, 31, 9, 1'b1);
    idle(WORD_W);
    step(1'b1, 31, 8'h0F, 1'b0);
    check("done_commit9", {24'd0, value}, 32'd9);
    step(1'b0, 0, 0, 1'b0);
    check("done_then_0f", {24'd0, value}, 32'h0F);
    check("done_busy_low", {31'd0, bus.busy}, 32'd0);

    // reset mid-conversion
    step(1'b1, 31, 200, 1'b1);
    idle(3);
    do_reset();
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit en;
      int addr;
      en   = ($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : 31;
      step(en, addr, $urandom_range(0, 255), $urandom_range(0, 1) == 1);
      if (i == 200) do_reset();
    end
    idle(WORD_W + 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
